// File: rtl/tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tracker_pkg
//  Description : Shared definitions for the line tracker: drive-mode codes
//                (identical to the motor block's case encoding), the
//                decision FSM state enum, and small helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package tracker_pkg;

    // Drive-mode codes consumed by the motor controller.
    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_FWD   = 2'b11;

    // Decision FSM states; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FOLLOW = 2'b01,
        SEARCH = 2'b10,
        HALT   = 2'b11
    } tracker_state_e;

    // Map debounced {left, mid, right} to a drive mode. 000 returns
    // MODE_STOP, but the FSM treats that pattern as "line lost" before
    // ever using the table value.
    function automatic logic [1:0] decide_mode(input logic [2:0] lmr);
        logic [1:0] m;
        case (lmr)
            3'b010, 3'b111, 3'b101: m = MODE_FWD;
            3'b100, 3'b110:         m = MODE_LEFT;
            3'b001, 3'b011:         m = MODE_RIGHT;
            default:                m = MODE_STOP;
        endcase
        return m;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : tracker_pkg
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_debounce
//  Description : Two-flop synchroniser followed by a stability counter for
//                one asynchronous sensor bit. The debounced output only
//                follows the synchronised input after it has differed for
//                DEB_CYCLES consecutive cycles (total latency 2+DEB_CYCLES).
//  Ports       : clk    system clock
//                rst    synchronous active-high reset
//                i_raw  asynchronous input bit
//                o_deb  debounced, clk-synchronous output bit
//  Revision    : 1.0  initial release
// ============================================================================
module sensor_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int                 c_cnt_w   = $clog2(DEB_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

    logic               meta_q, meta_d;
    logic               sync_q, sync_d;
    logic               deb_q,  deb_d;
    logic [c_cnt_w-1:0] cnt_q,  cnt_d;

    always_comb begin
        meta_d = i_raw;
        sync_d = meta_q;
        deb_d  = deb_q;
        cnt_d  = '0;
        // Any cycle where the synced bit agrees with the output restarts
        // the stability count, so short glitches never accumulate.
        if (sync_q != deb_q) begin
            if (cnt_q >= c_cnt_max) begin
                deb_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_deb = deb_q;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/line_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : line_tracker
//  Description : Decision stage of the line-following car. Synchronises and
//                debounces three IR sensors, synchronises the obstacle flag,
//                and runs an IDLE/FOLLOW/SEARCH/HALT state machine with a
//                minimum-hold anti-chatter timer and a line-lost timeout.
//  Ports       : clk         100 MHz system clock
//                rst         synchronous active-high reset
//                enable      run request (level)
//                sensor_raw  async IR sensors {left, mid, right}, 1 = line
//                obstacle    async obstacle-close flag, 1 = stop
//                mode        registered drive mode (00 stop, 01 left,
//                            10 right, 11 forward)
//                state       FSM state for debug LEDs
//                lost        high while in SEARCH or HALT
//  Revision    : 1.0  initial release
// ============================================================================
module line_tracker
    import tracker_pkg::*;
#(
    parameter int DEB_CYCLES   = 100000,
    parameter int MIN_HOLD     = 2000000,
    parameter int LOST_TIMEOUT = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sensor_raw,
    input  logic       obstacle,
    output logic [1:0] mode,
    output logic [1:0] state,
    output logic       lost
);

    localparam int c_cnt_w =
        $clog2(max_int(DEB_CYCLES, max_int(MIN_HOLD, LOST_TIMEOUT))) + 1;
    localparam logic [c_cnt_w-1:0] c_hold_max   = c_cnt_w'(MIN_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_search_max = c_cnt_w'(LOST_TIMEOUT - 1);

    logic [2:0]         deb;
    logic [1:0]         table_mode;
    logic               obs_meta_q, obs_meta_d;
    logic               obs_sync_q, obs_sync_d;
    tracker_state_e     state_q, state_d;
    logic [1:0]         fsm_mode_q, fsm_mode_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         last_dir_q, last_dir_d;
    logic               lost_q, lost_d;
    logic [c_cnt_w-1:0] hold_cnt_q, hold_cnt_d;
    logic [c_cnt_w-1:0] search_cnt_q, search_cnt_d;

    // ------------------------------------------------------------------
    // Sensor conditioning: one sync+debounce slice per sensor bit.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_sensor
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .i_raw (sensor_raw[i]),
            .o_deb (deb[i])
        );
    end

    assign table_mode = decide_mode(deb);

    // Obstacle needs a fast reaction, so it is synchronised but not debounced.
    always_comb begin
        obs_meta_d = obstacle;
        obs_sync_d = obs_meta_q;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            obs_meta_q   <= 1'b0;
            obs_sync_q   <= 1'b0;
            state_q      <= IDLE;
            fsm_mode_q   <= MODE_STOP;
            mode_q       <= MODE_STOP;
            last_dir_q   <= MODE_LEFT;
            lost_q       <= 1'b0;
            hold_cnt_q   <= '0;
            search_cnt_q <= '0;
        end else begin
            obs_meta_q   <= obs_meta_d;
            obs_sync_q   <= obs_sync_d;
            state_q      <= state_d;
            fsm_mode_q   <= fsm_mode_d;
            mode_q       <= mode_d;
            last_dir_q   <= last_dir_d;
            lost_q       <= lost_d;
            hold_cnt_q   <= hold_cnt_d;
            search_cnt_q <= search_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. fsm_mode is the mode the state machine wants; the
    // obstacle override is applied only at the output so the FSM can
    // resume exactly where it stopped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fsm_mode_d   = fsm_mode_q;
        hold_cnt_d   = hold_cnt_q;
        search_cnt_d = search_cnt_q;

        if (!enable) begin
            state_d    = IDLE;
            fsm_mode_d = MODE_STOP;
        end else if (obs_sync_q) begin
            // Frozen: state and both timers keep their values.
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = FOLLOW;
                    fsm_mode_d = MODE_STOP;
                    hold_cnt_d = '0;
                end
                FOLLOW: begin
                    if (deb == 3'b000) begin
                        // Losing the line bypasses the hold timer.
                        state_d      = SEARCH;
                        search_cnt_d = '0;
                        fsm_mode_d   = last_dir_q;
                    end else if ((table_mode != fsm_mode_q) &&
                                 (hold_cnt_q >= c_hold_max)) begin
                        fsm_mode_d = table_mode;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q < c_hold_max) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                SEARCH: begin
                    if (deb != 3'b000) begin
                        state_d    = FOLLOW;
                        fsm_mode_d = table_mode;
                        hold_cnt_d = '0;
                    end else if (search_cnt_q >= c_search_max) begin
                        state_d    = HALT;
                        fsm_mode_d = MODE_STOP;
                    end else begin
                        search_cnt_d = search_cnt_q + 1'b1;
                    end
                end
                HALT: begin
                    // Leaving HALT requires enable to drop first.
                    fsm_mode_d = MODE_STOP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        last_dir_d = last_dir_q;
        if ((fsm_mode_d == MODE_LEFT) || (fsm_mode_d == MODE_RIGHT)) begin
            last_dir_d = fsm_mode_d;
        end

        // Registering against the synchroniser's next value makes mode read
        // 00 in exactly the cycles where the synced obstacle flag is high.
        if (!enable || obs_sync_d) begin
            mode_d = MODE_STOP;
        end else begin
            mode_d = fsm_mode_d;
        end

        lost_d = (state_d == SEARCH) || (state_d == HALT);
    end

    assign mode  = mode_q;
    assign state = state_q;
    assign lost  = lost_q;

endmodule : line_tracker
`default_nettype wire

// File: tb/tb_line_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_tracker
//  Description : Self-checking bench for line_tracker with short timing
//                parameters. A behavioural reference model advances on each
//                rising edge; every falling edge the DUT outputs are compared
//                against it. Directed phases add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_tracker;

    localparam int DEB = 4;
    localparam int MH  = 8;
    localparam int LT  = 20;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] sensor_raw;
    logic       obstacle;
    logic [1:0] mode;
    logic [1:0] state;
    logic       lost;

    int n_checks = 0;
    int n_err    = 0;

    line_tracker #(
        .DEB_CYCLES   (DEB),
        .MIN_HOLD     (MH),
        .LOST_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sensor_raw (sensor_raw),
        .obstacle   (obstacle),
        .mode       (mode),
        .state      (state),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Synchronisers are modelled as sample histories,
    // debounce as a run-length of disagreeing samples, and steering from
    // which side of the car sees the line.
    // ------------------------------------------------------------------
    int m_s1 [4];     // [0..2] sensors right..left, [3] obstacle
    int m_s2 [4];
    int m_deb[3];
    int m_run[3];
    int m_st, m_fmode, m_last, m_hold, m_search, m_mode, m_lost;
    bit m_valid = 1'b0;

    function automatic int steer(input int l, input int m, input int r);
        if (l != 0 && r == 0) return 1;          // line on left only
        if (r != 0 && l == 0) return 2;          // line on right only
        if (l != 0 || m != 0 || r != 0) return 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        int raw[4];
        int dir;
        int any;
        raw[0] = int'(sensor_raw[0]);
        raw[1] = int'(sensor_raw[1]);
        raw[2] = int'(sensor_raw[2]);
        raw[3] = int'(obstacle);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin m_s1[i] = 0; m_s2[i] = 0; end
            for (int i = 0; i < 3; i++) begin m_deb[i] = 0; m_run[i] = 0; end
            m_st = 0; m_fmode = 0; m_last = 1; m_hold = 0; m_search = 0;
            m_mode = 0; m_lost = 0;
            m_valid = 1'b1;
        end else begin
            dir = steer(m_deb[2], m_deb[1], m_deb[0]);
            any = m_deb[2] | m_deb[1] | m_deb[0];
            if (enable == 1'b0) begin
                m_st = 0; m_fmode = 0;
            end else if (m_s2[3] == 0) begin
                case (m_st)
                    0: begin m_st = 1; m_hold = 0; m_fmode = 0; end
                    1: begin
                        if (any == 0) begin
                            m_st = 2; m_search = 0; m_fmode = m_last;
                        end else if (dir != m_fmode && m_hold >= MH - 1) begin
                            m_fmode = dir; m_hold = 0;
                        end else if (m_hold < MH - 1) begin
                            m_hold++;
                        end
                    end
                    2: begin
                        if (any != 0) begin
                            m_st = 1; m_fmode = dir; m_hold = 0;
                        end else if (m_search >= LT - 1) begin
                            m_st = 3; m_fmode = 0;
                        end else begin
                            m_search++;
                        end
                    end
                    default: m_fmode = 0;
                endcase
            end
            if (m_fmode == 1 || m_fmode == 2) m_last = m_fmode;
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= DEB) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            m_mode = (enable == 1'b0 || m_s2[3] != 0) ? 0 : m_fmode;
            m_lost = (m_st >= 2) ? 1 : 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_mode",  int'(mode),  m_mode);
            chk("cyc_state", int'(state), m_st);
            chk("cyc_lost",  int'(lost),  m_lost);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; enable = 1'b0; sensor_raw = 3'b000; obstacle = 1'b0;
        wait_cyc(2);
        chk("rst_mode", int'(mode), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_lost", int'(lost), 0);
        rst = 1'b0; sensor_raw = 3'b010;

        // Start-up: line under mid sensor, then enable.
        wait_cyc(8);
        chk("idle_mode", int'(mode), 0);
        enable = 1'b1;
        wait_cyc(1);
        chk("en_state_follow", int'(state), 1);
        chk("en_mode_stop", int'(mode), 0);
        wait_cyc(7);
        chk("hold_not_done", int'(mode), 0);
        wait_cyc(1);
        chk("fwd_after_hold", int'(mode), 3);
        chk("fwd_lost", int'(lost), 0);

        // Glitch of 3 cycles must be filtered.
        sensor_raw = 3'b110;
        wait_cyc(3);
        sensor_raw = 3'b010;
        wait_cyc(8);
        chk("glitch_filtered", int'(mode), 3);

        // Sustained 110 -> left after debounce.
        sensor_raw = 3'b110;
        wait_cyc(6);
        chk("left_pending", int'(mode), 3);
        wait_cyc(1);
        chk("left_taken", int'(mode), 1);

        // Right turn: debounce done after 6, hold timer delays to 8.
        sensor_raw = 3'b011;
        wait_cyc(7);
        chk("right_held_off", int'(mode), 1);
        wait_cyc(1);
        chk("right_taken", int'(mode), 2);

        // Line lost -> SEARCH with last direction, then timeout to HALT.
        sensor_raw = 3'b000;
        wait_cyc(6);
        chk("pre_search", int'(state), 1);
        wait_cyc(1);
        chk("search_state", int'(state), 2);
        chk("search_mode", int'(mode), 2);
        chk("search_lost", int'(lost), 1);
        wait_cyc(19);
        chk("search_last", int'(state), 2);
        wait_cyc(1);
        chk("halt_state", int'(state), 3);
        chk("halt_mode", int'(mode), 0);
        chk("halt_lost", int'(lost), 1);
        wait_cyc(3);
        chk("halt_sticky", int'(state), 3);
        enable = 1'b0;
        wait_cyc(1);
        chk("halt_to_idle", int'(state), 0);
        chk("idle_lost", int'(lost), 0);

        // Re-enable with no line -> SEARCH, then recover on 001.
        enable = 1'b1;
        wait_cyc(2);
        chk("reen_search", int'(state), 2);
        chk("reen_mode", int'(mode), 2);
        wait_cyc(3);
        sensor_raw = 3'b001;
        wait_cyc(6);
        chk("recover_pending", int'(state), 2);
        wait_cyc(1);
        chk("recover_state", int'(state), 1);
        chk("recover_mode", int'(mode), 2);
        chk("recover_lost", int'(lost), 0);

        // Obstacle: reach forward, let hold reach 2, then block for 10.
        sensor_raw = 3'b010;
        for (int i = 0; i < 40 && m_mode != 3; i++) @(negedge clk);
        chk("obs_setup_fwd", int'(mode), 3);
        wait_cyc(2);
        obstacle = 1'b1; sensor_raw = 3'b110;
        wait_cyc(1);
        chk("obs_sync_delay", int'(mode), 3);
        wait_cyc(1);
        chk("obs_stop", int'(mode), 0);
        wait_cyc(8);
        chk("obs_still_stop", int'(mode), 0);
        chk("obs_state_frozen", int'(state), 1);
        obstacle = 1'b0;
        wait_cyc(2);
        chk("obs_resume", int'(mode), 3);
        wait_cyc(3);
        chk("obs_hold_kept", int'(mode), 3);
        wait_cyc(1);
        chk("obs_hold_expire", int'(mode), 1);

        // Reset in the middle of SEARCH after a right turn.
        sensor_raw = 3'b011;
        wait_cyc(10);
        sensor_raw = 3'b000;
        wait_cyc(9);
        chk("pre_rst_search", int'(state), 2);
        chk("pre_rst_mode", int'(mode), 2);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_lost", int'(lost), 0);
        wait_cyc(1);
        chk("post_rst_follow", int'(state), 1);
        wait_cyc(1);
        chk("post_rst_search", int'(state), 2);
        chk("last_dir_reset", int'(mode), 1);

        // Dropping enable in SEARCH returns to IDLE next cycle.
        enable = 1'b0;
        wait_cyc(1);
        chk("dis_state", int'(state), 0);
        chk("dis_mode", int'(mode), 0);
        chk("dis_lost", int'(lost), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_line_tracker
`default_nettype wire
